// File: rtl/alu_mc_pkg.sv
// Shared opcode, state and flag definitions for the multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_mc_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
  localparam logic [OP_W-1:0] OP_PASS = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
  localparam logic [OP_W-1:0] OP_ADC  = 4'd9;
  localparam logic [OP_W-1:0] OP_SBC  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Flag vector layout: {N, V, C, Z}
  localparam int NFLAGS = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between operand source, ALU and result sink.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals: in_valid/in_ready/A/B/op carry an operation into the ALU;
// out_valid/out_ready/Y/Y_hi/Z/C/V/N carry the result and flags out.
// slave = ALU side, master = source/sink side.
interface alu_mc_if
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OP_W-1:0]  op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_hi;
  logic             Z;
  logic             C;
  logic             V;
  logic             N;

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Y, Y_hi, Z, C, V, N
  );

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Y, Y_hi, Z, C, V, N
  );
endinterface

// File: rtl/alu_mc_core.sv
// Combinational single-cycle datapath: add/sub with carry, logic, shifts, pass.
// Latency: 0 (purely combinational; caller registers the result).
// Backpressure: none; output follows inputs.
//
// Ports: i_a, i_b operands; i_op opcode; i_cin stored carry used by ADC/SBC;
//        o_y result; o_flags {N,V,C,Z}.
module alu_mc_core
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [OP_W-1:0]   i_op,
  input  logic              i_cin,
  output logic [WIDTH-1:0]  o_y,
  output logic [NFLAGS-1:0] o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_v;
  logic             w_cin_eff;

  always_comb begin
    w_sum     = '0;
    w_y       = i_a;
    w_c       = 1'b0;
    w_v       = 1'b0;
    // Only the carry-chained ops consume the stored carry.
    w_cin_eff = ((i_op == OP_ADC) || (i_op == OP_SBC)) ? i_cin : 1'b0;

    case (i_op)
      OP_ADD, OP_ADC: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_cin_eff};
        w_y   = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        // Extra MSB goes high exactly when A < B + cin (borrow).
        w_sum = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, w_cin_eff};
        w_y   = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: w_y = i_a & i_b;
      OP_OR:  w_y = i_a | i_b;
      OP_XOR: w_y = i_a ^ i_b;
      OP_SHL: begin
        w_y = {i_a[WIDTH-2:0], 1'b0};
        w_c = i_a[WIDTH-1];
      end
      OP_SHR: begin
        w_y = {1'b0, i_a[WIDTH-1:1]};
        w_c = i_a[0];
      end
      // PASS and the reserved opcodes all forward A with C=V=0.
      default: w_y = i_a;
    endcase

    o_y             = w_y;
    o_flags         = '0;
    o_flags[FLAG_Z] = (w_y == '0);
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
    o_flags[FLAG_N] = w_y[WIDTH-1];
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready on both sides and shift-add multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL; one op outstanding.
// Backpressure: in_ready drops while MUL runs or while an unaccepted result is held.
//
// Ports: clk, rst_n (async active-low); bus = alu_mc_if slave
//        (in_valid/in_ready/A/B/op in, out_valid/out_ready/Y/Y_hi/Z/C/V/N out).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // State and registered outputs
  state_t              r_state,     w_state;
  logic                r_out_valid, w_out_valid;
  logic [WIDTH-1:0]    r_y,         w_y;
  logic [WIDTH-1:0]    r_y_hi,      w_y_hi;
  logic [NFLAGS-1:0]   r_flags,     w_flags;
  logic                r_carry,     w_carry;

  // Multiplier working registers
  logic [2*WIDTH-1:0]  r_a_sh,      w_a_sh;
  logic [WIDTH-1:0]    r_b_sh,      w_b_sh;
  logic [2*WIDTH-1:0]  r_acc,       w_acc;
  logic [CNT_W-1:0]    r_cnt,       w_cnt;

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [WIDTH-1:0]    w_core_y;
  logic [NFLAGS-1:0]   w_core_flags;
  logic [2*WIDTH-1:0]  w_addend;
  logic [2*WIDTH-1:0]  w_acc_sum;

  alu_mc_core #(.WIDTH(WIDTH)) u_core (
    .i_a     (bus.A),
    .i_b     (bus.B),
    .i_op    (bus.op),
    .i_cin   (r_carry),
    .o_y     (w_core_y),
    .o_flags (w_core_flags)
  );

  // rst_n gates in_ready so nothing is offered as accepted while held in reset.
  assign w_in_ready = rst_n && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  assign w_addend   = r_b_sh[0] ? r_a_sh : '0;
  assign w_acc_sum  = r_acc + w_addend;

  always_comb begin
    w_state     = r_state;
    w_out_valid = r_out_valid;
    w_y         = r_y;
    w_y_hi      = r_y_hi;
    w_flags     = r_flags;
    w_carry     = r_carry;
    w_a_sh      = r_a_sh;
    w_b_sh      = r_b_sh;
    w_acc       = r_acc;
    w_cnt       = r_cnt;

    if (w_out_fire) begin
      w_out_valid = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          if (bus.op == OP_MUL) begin
            w_a_sh = {{WIDTH{1'b0}}, bus.A};
            w_b_sh = bus.B;
            w_acc  = '0;
            w_cnt  = '0;
            w_state = ST_MUL;
          end else begin
            // A new result loading on the same edge as an output transfer
            // overrides the deassert above.
            w_y         = w_core_y;
            w_y_hi      = '0;
            w_flags     = w_core_flags;
            w_carry     = w_core_flags[FLAG_C];
            w_out_valid = 1'b1;
          end
        end
      end

      ST_MUL: begin
        w_acc  = w_acc_sum;
        w_a_sh = {r_a_sh[2*WIDTH-2:0], 1'b0};
        w_b_sh = {1'b0, r_b_sh[WIDTH-1:1]};
        w_cnt  = r_cnt + 1'b1;
        // Always runs all WIDTH iterations so latency is data-independent.
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_y             = w_acc_sum[WIDTH-1:0];
          w_y_hi          = w_acc_sum[2*WIDTH-1:WIDTH];
          w_flags         = '0;
          w_flags[FLAG_Z] = (w_acc_sum == '0);
          w_flags[FLAG_C] = (w_acc_sum[2*WIDTH-1:WIDTH] != '0);
          w_flags[FLAG_V] = (w_acc_sum[2*WIDTH-1:WIDTH] != '0);
          w_flags[FLAG_N] = w_acc_sum[2*WIDTH-1];
          w_carry         = (w_acc_sum[2*WIDTH-1:WIDTH] != '0);
          w_out_valid     = 1'b1;
          w_state         = ST_IDLE;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_hi      <= '0;
      r_flags     <= '0;
      r_carry     <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_out_valid <= w_out_valid;
      r_y         <= w_y;
      r_y_hi      <= w_y_hi;
      r_flags     <= w_flags;
      r_carry     <= w_carry;
      r_a_sh      <= w_a_sh;
      r_b_sh      <= w_b_sh;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Y         = r_y;
  assign bus.Y_hi      = r_y_hi;
  assign bus.Z         = r_flags[FLAG_Z];
  assign bus.C         = r_flags[FLAG_C];
  assign bus.V         = r_flags[FLAG_V];
  assign bus.N         = r_flags[FLAG_N];

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed steps plus randomized ops vs. an arithmetic model.
// Latency: checks 1-cycle and WIDTH+1-cycle result timing.
// Backpressure: exercises out_ready=0 hold and same-edge re-accept.
module tb_alu_mc;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  logic model_carry = 1'b0;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] yhi;
    logic z, c, v, n;
  } res_t;

  // Reference model from arithmetic definitions using plain integers.
  function automatic res_t model(input int a, input int b, input int op, input int cin);
    res_t   r;
    longint m    = longint'(1) << W;
    longint half = m / 2;
    longint s, sa, sb, sv, p;
    int     ce;
    r  = '0;
    p  = 0;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    ce = (op == 9 || op == 10) ? cin : 0;
    case (op)
      0, 9: begin
        s = a + b + ce;  r.y = W'(s % m);  r.c = (s >= m);
        sv = sa + sb + ce;  r.v = (sv >= half) || (sv < -half);
      end
      1, 10: begin
        s = a - b - ce;  r.y = W'((s + 2 * m) % m);  r.c = (s < 0);
        sv = sa - sb - ce;  r.v = (sv >= half) || (sv < -half);
      end
      2: r.y = W'(a & b);
      3: r.y = W'(a | b);
      4: r.y = W'(a ^ b);
      5: begin r.y = W'((2 * a) % m); r.c = (a >= half); end
      6: begin r.y = W'(a / 2);       r.c = (a % 2 == 1); end
      8: begin
        p = longint'(a) * longint'(b);
        r.y = W'(p % m);  r.yhi = W'(p / m);
        r.c = (p / m != 0);  r.v = r.c;
      end
      default: r.y = W'(a);
    endcase
    if (op == 8) begin
      r.z = (p == 0);
      r.n = ((p / m) >= half);
    end else begin
      r.z = (r.y == 0);
      r.n = (longint'(r.y) >= half);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, "_vld"},  64'(bus.out_valid), 64'(1));
    chk({tag, "_y"},    64'(bus.Y),         64'(e.y));
    chk({tag, "_yhi"},  64'(bus.Y_hi),      64'(e.yhi));
    chk({tag, "_zcvn"}, 64'({bus.Z, bus.C, bus.V, bus.N}), 64'({e.z, e.c, e.v, e.n}));
  endtask

  // Present an op, wait (bounded) for in_ready, transfer on the next edge.
  task automatic issue(input int a, input int b, input int op, output res_t e);
    int k;
    bus.in_valid = 1'b1;
    bus.A  = W'(a);
    bus.B  = W'(b);
    bus.op = 4'(op);
    #1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      cyc();
      k++;
    end
    chk("issue_rdy", 64'(bus.in_ready), 64'(1));
    e = model(a, b, op, int'(model_carry));
    model_carry = e.c;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  // Cycles counted from the accept edge (1 = visible right after it).
  task automatic wait_res(output int n);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int op, output res_t e);
    int n;
    issue(a, b, op, e);
    wait_res(n);
    chk({tag, "_lat"}, 64'(n), (op == 8) ? 64'(W + 1) : 64'(1));
    check_res(tag, e);
  endtask

  initial begin
    res_t e;
    int   a, b, op;

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_outs", 64'({bus.Y, bus.Y_hi, bus.Z, bus.C, bus.V, bus.N}), 64'(0));
    rst_n = 1'b1;
    cyc();

    // Carry chain: ADD FF+01 then ADC 00+00 picks up the carry
    run_op("add_ff_01", 8'hFF, 8'h01, 0, e);
    chk("add_ff_01_lit", 64'({bus.Y, bus.Z, bus.C, bus.V, bus.N}), 64'({8'h00, 4'b1100}));
    run_op("adc_00_00", 8'h00, 8'h00, 9, e);
    chk("adc_lit", 64'({bus.Y, bus.C}), 64'({8'h01, 1'b0}));

    run_op("sub_00_01", 8'h00, 8'h01, 1, e);
    chk("sub_lit", 64'({bus.Y, bus.C, bus.N, bus.V}), 64'({8'hFF, 3'b110}));
    run_op("add_7f_01", 8'h7F, 8'h01, 0, e);
    chk("add_ovf_lit", 64'({bus.Y, bus.V, bus.N, bus.C}), 64'({8'h80, 3'b110}));

    // Multiplier
    run_op("mul_0f_11", 8'h0F, 8'h11, 8, e);
    chk("mul1_lit", 64'({bus.Y_hi, bus.Y, bus.C, bus.V}), 64'({16'h00FF, 2'b00}));
    run_op("mul_80_02", 8'h80, 8'h02, 8, e);
    chk("mul2_lit", 64'({bus.Y_hi, bus.Y, bus.C, bus.V, bus.Z}), 64'({16'h0100, 3'b110}));
    run_op("mul_00_b", 8'h00, 8'hA5, 8, e);

    // Backpressure: hold XOR result, then re-accept on the release edge
    issue(8'hFF, 8'h0F, 4, e);
    check_res("xor_bp", e);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_res("bp_hold", e);
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid  = 1'b1;
    bus.A         = 8'h3C;
    bus.B         = 8'h0F;
    bus.op        = 4'd2;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(bus.in_ready), 64'(1));
    e = model(8'h3C, 8'h0F, 2, int'(model_carry));
    model_carry = e.c;
    cyc();
    bus.in_valid = 1'b0;
    check_res("bp_next", e);

    // Throughput: 8 single-cycle ops on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        a = 8'h80; b = $urandom_range(0, 255); op = 5;
      end else if (i == 1) begin
        a = 8'h01; b = $urandom_range(0, 255); op = 6;
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        do op = $urandom_range(0, 15); while (op == 8);
      end
      bus.in_valid = 1'b1;
      bus.A  = W'(a);
      bus.B  = W'(b);
      bus.op = 4'(op);
      #1;
      chk("tp_in_ready", 64'(bus.in_ready), 64'(1));
      e = model(a, b, op, int'(model_carry));
      model_carry = e.c;
      cyc();
      check_res("tp", e);
    end
    bus.in_valid = 1'b0;
    cyc();

    // Randomized ops, including MUL and reserved opcodes
    for (int i = 0; i < 24; i++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      run_op("rnd", a, b, op, e);
    end

    // Reset in the middle of a MUL
    run_op("pre_rst", 8'h7F, 8'h01, 0, e);
    issue(8'hFF, 8'hFF, 8, e);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_outs", 64'({bus.out_valid, bus.Y, bus.Y_hi, bus.Z, bus.C, bus.V, bus.N}), 64'(0));
    chk("midmul_rst_rdy", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_carry = 1'b0;
    cyc();
    run_op("post_rst_add", 8'h05, 8'h03, 0, e);
    chk("post_rst_lit", 64'({bus.Y, bus.Z, bus.C, bus.V, bus.N}), 64'({8'h08, 4'b0000}));
    run_op("post_rst_adc", 8'h01, 8'h01, 9, e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
